// File: rtl/adc_pkg.sv
// adc_pkg: FSM state encoding and default parameters shared by the ADC SPI receiver
package adc_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam logic [1:0] ST_QUIET = 2'd3;
   localparam int ADC_CHANNELS     = 2;
   localparam int ADC_FRAME_BITS   = 16;
   localparam int ADC_DATA_BITS    = 12;
   localparam int ADC_CLK_DIV      = 4;
   localparam int ADC_QUIET_CYCLES = 4;
endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: SCLK divider with rise strobe and rising-edge counter
// clk_i/rst_i: clock and sync active-high reset; en_i: run (low forces sclk high, counters clear)
// sclk_o: serial clock; rise_o: high in the cycle whose closing edge drives sclk 0->1
// edges_o: rising edges completed so far in this frame
module adc_sclk_gen import adc_pkg::*; #(
   parameter int CLK_DIV    = ADC_CLK_DIV,
   parameter int FRAME_BITS = ADC_FRAME_BITS
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            en_i,
   output logic                            sclk_o,
   output logic                            rise_o,
   output logic [$clog2(FRAME_BITS+1)-1:0] edges_o
);
   localparam int DW = $clog2(CLK_DIV+1);
   localparam int EW = $clog2(FRAME_BITS+1);
   logic [DW-1:0] div_q, div_d;
   logic [EW-1:0] edges_q, edges_d;
   logic          sclk_q, sclk_d, wrap;
   always_comb begin
      wrap    = en_i && div_q == DW'(CLK_DIV-1);
      rise_o  = wrap && !sclk_q;
      div_d   = (!en_i || wrap) ? '0 : div_q + 1'b1;
      sclk_d  = !en_i ? 1'b1 : sclk_q ^ wrap;
      edges_d = !en_i ? '0 : edges_q + EW'(rise_o);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q   <= '0;
         sclk_q  <= 1'b1;
         edges_q <= '0;
      end else begin
         div_q   <= div_d;
         sclk_q  <= sclk_d;
         edges_q <= edges_d;
      end
   end
   assign sclk_o  = sclk_q;
   assign edges_o = edges_q;
endmodule

// File: rtl/adc_spi_rx_multi.sv
// adc_spi_rx_multi: multi-channel SPI ADC receiver sharing one CS/SCLK
// clk_nexys/reset: clock and sync active-high reset; rx_en: request; continuous: back-to-back frames
// adc_data: one serial line per channel; cs/sclk: bus outputs; busy: not IDLE
// rx_done_tick: pulse with data_out update; data_out: channel k at [k*DATA_BITS +: DATA_BITS]
// frame_err: leading-bit check, built only with ADC_RX_LEADING_CHECK_EN defined (else 0)
module adc_spi_rx_multi import adc_pkg::*; #(
   parameter int CHANNELS     = ADC_CHANNELS,
   parameter int FRAME_BITS   = ADC_FRAME_BITS,
   parameter int DATA_BITS    = ADC_DATA_BITS,
   parameter int CLK_DIV      = ADC_CLK_DIV,
   parameter int QUIET_CYCLES = ADC_QUIET_CYCLES
) (
   input  logic                          clk_nexys,
   input  logic                          reset,
   input  logic                          rx_en,
   input  logic                          continuous,
   input  logic [CHANNELS-1:0]           adc_data,
   output logic                          cs,
   output logic                          sclk,
   output logic                          busy,
   output logic                          rx_done_tick,
   output logic [CHANNELS*DATA_BITS-1:0] data_out,
   output logic                          frame_err
);
   localparam int EW = $clog2(FRAME_BITS+1);
   localparam int QW = $clog2(QUIET_CYCLES+1);
   logic [1:0]    state_q, state_d;
   logic [QW-1:0] cnt_q, cnt_d;
   logic [EW-1:0] edges;
   logic          rise, last, quiet_end;
   adc_sclk_gen #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS)) u_sclk (
      .clk_i  (clk_nexys),
      .rst_i  (reset),
      .en_i   (state_q == ST_SHIFT),
      .sclk_o (sclk),
      .rise_o (rise),
      .edges_o(edges)
   );
   // data_out is loaded on the edge that enters DONE, so it is already valid during the done pulse
   assign last = rise && edges == EW'(FRAME_BITS-1);
   always_comb begin
      quiet_end = state_q == ST_QUIET && cnt_q == QW'(QUIET_CYCLES-1);
      cnt_d     = state_q == ST_QUIET ? cnt_q + 1'b1 : '0;
      state_d   = state_q == ST_IDLE  ? (rx_en ? ST_SHIFT : ST_IDLE) :
                  state_q == ST_SHIFT ? (last ? ST_DONE : ST_SHIFT) :
                  state_q == ST_DONE  ? ST_QUIET :
                  !quiet_end          ? ST_QUIET :
                  (continuous && rx_en) ? ST_SHIFT : ST_IDLE;
   end
   always_ff @(posedge clk_nexys) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   assign cs           = state_q != ST_SHIFT;
   assign busy         = state_q != ST_IDLE;
   assign rx_done_tick = state_q == ST_DONE;
`ifdef ADC_RX_LEADING_CHECK_EN
   logic [CHANNELS-1:0] lead;
   logic                err_q;
`endif
   genvar k;
   for (k = 0; k < CHANNELS; k++) begin : g_ch
      logic [FRAME_BITS-1:0] sh_q, sh_d;
      logic [DATA_BITS-1:0]  dat_q;
      assign sh_d = rise ? (sh_q << 1) | FRAME_BITS'(adc_data[k]) : sh_q;
      always_ff @(posedge clk_nexys) begin
         if (reset) begin
            sh_q  <= '0;
            dat_q <= '0;
         end else begin
            sh_q  <= sh_d;
            dat_q <= last ? sh_d[DATA_BITS-1:0] : dat_q;
         end
      end
      assign data_out[k*DATA_BITS +: DATA_BITS] = dat_q;
`ifdef ADC_RX_LEADING_CHECK_EN
      if (FRAME_BITS > DATA_BITS) begin : g_lead
         assign lead[k] = |sh_d[FRAME_BITS-1:DATA_BITS];
      end else begin : g_nolead
         assign lead[k] = 1'b0;
      end
`endif
   end
`ifdef ADC_RX_LEADING_CHECK_EN
   always_ff @(posedge clk_nexys) begin
      if (reset) err_q <= 1'b0;
      else err_q <= last ? |lead : err_q;
   end
   assign frame_err = err_q;
`else
   assign frame_err = 1'b0;
`endif
endmodule

// File: doc/adc_spi_rx_multi.md
ADC_SPI_RX_MULTI -- requirements
Module: adc_spi_rx_multi

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): CHANNELS, 2, number of parallel serial data lines sharing one CS/SCLK.
REQ-002 FRAME_BITS, 16, SCLK rising edges per conversion frame.
REQ-003 DATA_BITS, 12, result bits taken from the LSB end of each frame (DATA_BITS <= FRAME_BITS).
REQ-004 CLK_DIV, 4, clk_nexys cycles per SCLK half-period (>= 1).
REQ-005 QUIET_CYCLES, 4, minimum CS-high cycles after the done cycle (>= 1).
REQ-006 The block SHALL have these ports (name, direction, width, meaning): clk_nexys, in, 1, single clock; all logic is on its rising edge.
REQ-007 reset, in, 1, synchronous, active-high.
REQ-008 rx_en, in, 1, request a conversion.
REQ-009 continuous, in, 1, 1 = back-to-back frames while rx_en is high.
REQ-010 adc_data, in, CHANNELS, serial data from each converter.
REQ-011 cs, out, 1, active-low chip select.
REQ-012 sclk, out, 1, serial clock; idles high.
REQ-013 busy, out, 1, high in every state except IDLE.
REQ-014 rx_done_tick, out, 1, one-cycle pulse when data_out updates.
REQ-015 data_out, out, CHANNELS*DATA_BITS, channel k in bits [k*DATA_BITS +: DATA_BITS].
REQ-016 frame_err, out, 1, leading-bit check result (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, SHIFT, DONE and QUIET.
REQ-018 In IDLE with rx_en=1 at a rising edge, the next cycle SHALL be SHIFT with cs=0.
REQ-019 In SHIFT, sclk SHALL go low after CLK_DIV cycles and toggle every CLK_DIV cycles thereafter.
REQ-020 On each low-to-high sclk transition, each adc_data[k] SHALL be shifted MSB-first into its own FRAME_BITS shift register.
REQ-021 After the FRAME_BITS-th rising edge, the FSM SHALL enter DONE with cs=1 and sclk=1; cs SHALL be low for exactly 2*CLK_DIV*FRAME_BITS cycles (128 at defaults).
REQ-022 In DONE, data_out SHALL load the low DATA_BITS of every shift register and rx_done_tick=1, for exactly one cycle.
REQ-023 QUIET SHALL last QUIET_CYCLES cycles with cs=1; it then goes to SHIFT if continuous=1 and rx_en=1, and to IDLE otherwise.
REQ-024 In continuous mode the cs-high gap SHALL be exactly 1+QUIET_CYCLES cycles.
REQ-025 A drop of rx_en during SHIFT SHALL NOT abort the frame; the frame completes and rx_done_tick fires.
REQ-026 data_out SHALL hold its value between done pulses.
REQ-027 Changes to continuous SHALL be sampled only at the end of QUIET.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL set state=IDLE, cs=1, sclk=1, busy=0, rx_done_tick=0, data_out=0, frame_err=0, and clear the shift registers and counters.
REQ-029 Reset SHALL dominate all other inputs, including mid-frame; a partial frame SHALL be discarded with no rx_done_tick.

Configuration
REQ-030 With ADC_RX_LEADING_CHECK_EN defined, the block SHALL set frame_err in DONE (registered with data_out) if any of the top FRAME_BITS-DATA_BITS bits of any channel is 1, and clear it otherwise.
REQ-031 Without ADC_RX_LEADING_CHECK_EN, frame_err SHALL be constant 0 and no check logic SHALL be built.

Structure
REQ-032 The shared package adc_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-033 The block SHALL use one sub-module, adc_sclk_gen, that generates the CLK_DIV divider, sclk, a one-cycle rise-strobe and the edge counter.
REQ-034 The per-channel shift registers SHALL be built with a generate loop over CHANNELS.

Verification
REQ-035 Single frame at defaults, ch0 sends 0x0ABC and ch1 sends 0x0123 -> cs low for 128 cycles, one rx_done_tick, data_out=24'h123ABC, frame_err=0.
REQ-036 rx_en held high with continuous=1 for 3 frames -> 3 rx_done_ticks, cs-high gaps of exactly 5 cycles, sclk high whenever cs is high.
REQ-037 reset asserted at the 7th sclk rising edge -> next cycle cs=1, sclk=1, data_out=0; no rx_done_tick; a following frame decodes correctly.
REQ-038 rx_en pulsed for 1 cycle with continuous=0 -> exactly one frame, then IDLE with busy=0.
REQ-039 With ADC_RX_LEADING_CHECK_EN defined, ch1 sends 0x8123 -> frame_err=1 in the done cycle, data_out[23:12]=12'h123; the next clean frame clears frame_err.
REQ-040 With CHANNELS=1, FRAME_BITS=14, DATA_BITS=12, CLK_DIV=2, sending 0x0FFF -> cs low 56 cycles, data_out=12'hFFF.
